// File: rtl/apb_fifo_mc_pkg.sv
// Shared register map, field positions and depth-select encoding for the
// multi-channel APB FIFO.
package apb_fifo_mc_pkg;

  // Register select, taken from PADDR[3:2] in the register window
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_THR  = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_ISR  = 2'd3;

  // CTRL fields; the four IE bits are contiguous and share ISR bit order
  localparam int CTRL_DSEL_LSB = 0;
  localparam int CTRL_FLUSH    = 8;
  localparam int CTRL_IE_LSB   = 16;

  // THR fields
  localparam int THR_AF_LSB = 0;
  localparam int THR_AE_LSB = 16;

  // STAT fields
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_EMPTY     = 16;
  localparam int STAT_FULL      = 17;
  localparam int STAT_AFULL     = 18;
  localparam int STAT_AEMPTY    = 19;

  // ISR bits
  localparam int ISR_OVF = 0;
  localparam int ISR_UDF = 1;
  localparam int ISR_AF  = 2;
  localparam int ISR_AE  = 3;

  // Depth-select encoding: depth = DSEL_MIN_DEPTH << DSEL
  localparam int         DSEL_W         = 3;
  localparam int         CNT_W          = 9;
  localparam logic [8:0] DSEL_MIN_DEPTH = 9'd8;
  localparam logic [2:0] DSEL_RST       = 3'd0;
  localparam logic [8:0] AF_THR_RST     = 9'd8;
  localparam logic [8:0] AE_THR_RST     = 9'd0;

  function automatic logic [2:0] dsel_max(input int max_depth);
    return 3'($clog2(max_depth) - 3);
  endfunction

  function automatic logic [8:0] dsel_depth(input logic [2:0] dsel);
    return DSEL_MIN_DEPTH << dsel;
  endfunction

endpackage

// File: rtl/apb_fifo_mc_chan.sv
// One FIFO channel: storage, pointers, occupancy, register file and sticky
// interrupt status. The top level hands it one already-decoded access.
module apb_fifo_mc_chan
  import apb_fifo_mc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        is_data,
  input  logic        write,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        err,
  output logic        full,
  output logic        empty,
  output logic        irq
);

  localparam int         AW       = $clog2(MAX_DEPTH);
  localparam logic [2:0] DSEL_MAX = dsel_max(MAX_DEPTH);

  logic [WIDTH-1:0] mem_q [MAX_DEPTH];

  logic [AW-1:0]     w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DSEL_W-1:0] dsel_q, dsel_d;
  logic [3:0]        ie_q, ie_d;
  logic [CNT_W-1:0]  af_thr_q, af_thr_d, ae_thr_q, ae_thr_d;
  logic [3:0]        isr_q, isr_d;

  logic [CNT_W-1:0]  depth;
  logic              afull, aempty;
  logic [31:0]       ctrl_rd, thr_rd, stat_rd, isr_rd, cur, mask, merged;
  logic [DSEL_W-1:0] new_dsel;
  logic              flush_req;
  logic              push_req, pop_req, reg_wr, reg_rd, push, pop;
  logic              ovf_set, udf_set, reg_err;
  logic [3:0]        isr_set, isr_clr;
  logic              unused_merged;

  // Pointers wrap at the currently selected depth, not at MAX_DEPTH
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p,
                                            input logic [CNT_W-1:0] d);
    return (CNT_W'(p) == d - 1'b1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    depth  = dsel_depth(dsel_q);
    full   = (count_q == depth);
    empty  = (count_q == '0);
    afull  = (count_q >= af_thr_q);
    aempty = (count_q <= ae_thr_q);

    ctrl_rd = '0;
    ctrl_rd[CTRL_DSEL_LSB +: DSEL_W] = dsel_q;
    ctrl_rd[CTRL_IE_LSB +: 4]        = ie_q;
    thr_rd = '0;
    thr_rd[THR_AF_LSB +: CNT_W] = af_thr_q;
    thr_rd[THR_AE_LSB +: CNT_W] = ae_thr_q;
    stat_rd = '0;
    stat_rd[STAT_COUNT_LSB +: CNT_W] = count_q;
    stat_rd[STAT_EMPTY]  = empty;
    stat_rd[STAT_FULL]   = full;
    stat_rd[STAT_AFULL]  = afull;
    stat_rd[STAT_AEMPTY] = aempty;
    isr_rd = '0;
    isr_rd[3:0] = isr_q;

    case (reg_sel)
      REG_CTRL: cur = ctrl_rd;
      REG_THR:  cur = thr_rd;
      REG_STAT: cur = stat_rd;
      default:  cur = isr_rd;
    endcase

    mask = '0;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{wstrb[b]}};
    merged    = (cur & ~mask) | (wdata & mask);
    new_dsel  = merged[CTRL_DSEL_LSB +: DSEL_W];
    flush_req = merged[CTRL_FLUSH];

    push_req = sel & is_data & write;
    pop_req  = sel & is_data & ~write;
    reg_wr   = sel & ~is_data & write;
    reg_rd   = sel & ~is_data & ~write;
    ovf_set  = push_req & full;
    udf_set  = pop_req & empty;

    // A flush empties the channel, so it may legally resize in the same write
    reg_err = 1'b0;
    if (reg_wr) begin
      if (reg_sel == REG_STAT) begin
        reg_err = 1'b1;
      end else if (reg_sel == REG_CTRL) begin
        if (new_dsel > DSEL_MAX) reg_err = 1'b1;
        else if ((new_dsel != dsel_q) && (count_q != '0) && !flush_req) reg_err = 1'b1;
      end
    end
    err  = ovf_set | udf_set | reg_err;
    push = push_req & ~full;
    pop  = pop_req & ~empty;

    w_ptr_d  = w_ptr_q;
    r_ptr_d  = r_ptr_q;
    count_d  = count_q;
    dsel_d   = dsel_q;
    ie_d     = ie_q;
    af_thr_d = af_thr_q;
    ae_thr_d = ae_thr_q;
    isr_clr  = '0;

    if (push) begin
      w_ptr_d = ptr_inc(w_ptr_q, depth);
      count_d = count_q + 1'b1;
    end
    if (pop) begin
      r_ptr_d = ptr_inc(r_ptr_q, depth);
      count_d = count_q - 1'b1;
    end
    if (reg_wr && !reg_err) begin
      case (reg_sel)
        REG_CTRL: begin
          dsel_d = new_dsel;
          ie_d   = merged[CTRL_IE_LSB +: 4];
          if (flush_req) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
          end
        end
        REG_THR: begin
          af_thr_d = merged[THR_AF_LSB +: CNT_W];
          ae_thr_d = merged[THR_AE_LSB +: CNT_W];
        end
        REG_ISR: isr_clr = wdata[3:0] & mask[3:0];
        default: ;
      endcase
    end

    // Hardware set dominates a same-cycle write-1-to-clear
    isr_set          = '0;
    isr_set[ISR_OVF] = ovf_set;
    isr_set[ISR_UDF] = udf_set;
    isr_set[ISR_AF]  = afull;
    isr_set[ISR_AE]  = aempty;
    isr_d = (isr_q & ~isr_clr) | isr_set;

    rdata = '0;
    if (pop)         rdata = 32'(mem_q[r_ptr_q]);
    else if (reg_rd) rdata = cur;

    irq = |(isr_q & ie_q);
  end

  assign unused_merged = ^{merged[31:25], merged[15:9]};

  always_ff @(posedge clk) begin
    if (push) mem_q[w_ptr_q] <= wdata[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q  <= '0;
      r_ptr_q  <= '0;
      count_q  <= '0;
      dsel_q   <= DSEL_RST;
      ie_q     <= '0;
      af_thr_q <= AF_THR_RST;
      ae_thr_q <= AE_THR_RST;
      isr_q    <= '0;
    end else begin
      w_ptr_q  <= w_ptr_d;
      r_ptr_q  <= r_ptr_d;
      count_q  <= count_d;
      dsel_q   <= dsel_d;
      ie_q     <= ie_d;
      af_thr_q <= af_thr_d;
      ae_thr_q <= ae_thr_d;
      isr_q    <= isr_d;
    end
  end

endmodule

// File: rtl/apb_fifo_mc.sv
// Multi-channel APB FIFO: decodes the data and register windows, routes each
// zero-wait-state access to one channel and muxes PRDATA/PSLVERR back.
module apb_fifo_mc
  import apb_fifo_mc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int MAX_DEPTH = 256
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic [31:0]    PADDR,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PWDATA,
  input  logic [3:0]     PSTRB,
  input  logic [2:0]     PPROT,
  output logic           PREADY,
  output logic [31:0]    PRDATA,
  output logic           PSLVERR,
  output logic [NCH-1:0] full,
  output logic [NCH-1:0] empty,
  output logic [NCH-1:0] irq
);

  // Valid/ready: an access completes in the single cycle PSEL&PENABLE is high;
  // PREADY is tied high so the completer never stalls the requester.
  logic        acc, data_win, addr_ok, ch_ok, dec_err, chan_err_any;
  logic [2:0]  ch;
  logic [1:0]  reg_sel;
  logic [31:0] rdata_or;
  logic [31:0] chan_rdata [NCH];
  logic [NCH-1:0] chan_err;
  logic        unused_in;

  always_comb begin
    // Reset aborts any transfer in flight
    acc      = PSEL & PENABLE & ~PRESET;
    data_win = PADDR[31];
    reg_sel  = PADDR[3:2];
    if (data_win) begin
      ch      = PADDR[4:2];
      addr_ok = (PADDR[30:5] == '0);
    end else begin
      ch      = PADDR[6:4];
      addr_ok = (PADDR[30:7] == '0);
    end
    ch_ok   = ({29'd0, ch} < 32'(NCH));
    dec_err = acc & ~(addr_ok & ch_ok);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    apb_fifo_mc_chan #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH)
    ) u_chan (
      .clk     (PCLK),
      .rst     (PRESET),
      .sel     (acc & addr_ok & ch_ok & (ch == 3'(i))),
      .is_data (data_win),
      .write   (PWRITE),
      .reg_sel (reg_sel),
      .wdata   (PWDATA),
      .wstrb   (PSTRB),
      .rdata   (chan_rdata[i]),
      .err     (chan_err[i]),
      .full    (full[i]),
      .empty   (empty[i]),
      .irq     (irq[i])
    );
  end

  // Unselected channels drive zero, so a plain OR acts as the mux
  always_comb begin
    rdata_or = '0;
    for (int i = 0; i < NCH; i++) rdata_or = rdata_or | chan_rdata[i];
    chan_err_any = |chan_err;
    PSLVERR      = dec_err | chan_err_any;
    PRDATA       = PSLVERR ? 32'd0 : rdata_or;
    PREADY       = 1'b1;
  end

  assign unused_in = ^{PPROT, PADDR[1:0]};

endmodule
